// File: rtl/tx_bit_encoder.sv
// tx_bit_encoder: paces raw bits, inserts stuffed zeros and NRZI-encodes the line
module tx_bit_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_active,
  input  logic tx_bit,
  input  logic tx_bit_valid,
  output logic tx_bit_ready,
  output logic bit_tick,
  output logic d_encoded,
  output logic stuffing,
  output logic underrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LEN + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] ones_q, ones_d;
  logic d_encoded_q, d_encoded_d, stuffing_q, stuffing_d, stuff_due;
  assign d_encoded = d_encoded_q;
  assign stuffing = stuffing_q;
  // slot decision on the tick: a due stuff beats a waiting bit, no bit means underrun
  always_comb begin
    bit_tick = tx_active && cnt_q == CW'(CLKS_PER_BIT - 1);
    stuff_due = ones_q == OW'(STUFF_LEN);
    tx_bit_ready = bit_tick && !stuff_due && tx_bit_valid;
    underrun = bit_tick && !stuff_due && !tx_bit_valid;
  end
  // next state: ticks apply the slot decision, idle forces the line back to J
  always_comb begin
    cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
    ones_d = ones_q;
    d_encoded_d = d_encoded_q;
    stuffing_d = stuffing_q;
    if (bit_tick) begin
      stuffing_d = stuff_due;
      d_encoded_d = d_encoded_q ^ (stuff_due || (tx_bit_ready && !tx_bit));
      ones_d = (tx_bit_ready && tx_bit) ? ones_q + 1'b1 : (underrun ? ones_q : '0);
    end
    if (!tx_active) begin
      cnt_d = '0;
      ones_d = '0;
      d_encoded_d = 1'b1;
      stuffing_d = 1'b0;
    end
  end
  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ones_q <= '0;
      d_encoded_q <= 1'b1;
      stuffing_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ones_q <= ones_d;
      d_encoded_q <= d_encoded_d;
      stuffing_q <= stuffing_d;
    end
  end
endmodule
